// File: rtl/async_fifo_pkg.sv
// ----------------------------------------------------------------------------
// async_fifo_pkg
// Shared helpers for the async FIFO write and read controllers.
//   bin2gray / gray2bin : pointer code conversion. They work on a fixed
//   MaxPtrW-bit container; callers zero-extend narrower pointers. Zero upper
//   bits are invariant under both conversions, so any width up to MaxPtrW
//   round-trips correctly.
// ----------------------------------------------------------------------------
package async_fifo_pkg;

    localparam int unsigned MaxPtrW = 32;

    typedef logic [MaxPtrW-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t bin);
        return bin ^ (bin >> 1);
    endfunction

    function automatic ptr_t gray2bin(input ptr_t gray);
        ptr_t bin;
        bin[MaxPtrW-1] = gray[MaxPtrW-1];
        for (int i = MaxPtrW - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/async_fifo_sync2.sv
// ----------------------------------------------------------------------------
// async_fifo_sync2
// Width-parameterised two-flop synchroniser, shared by both FIFO controllers.
//   clk_i  : destination-domain clock
//   rst_ni : asynchronous active-low reset, clears both stages to 0
//   d_i    : source-domain value (Gray coded, so at most one bit in flight)
//   q_o    : value synchronised into clk_i
// ----------------------------------------------------------------------------
module async_fifo_sync2 #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/async_fifo_wctrl.sv
// ----------------------------------------------------------------------------
// async_fifo_wctrl
// Write-domain pointer and status controller for the async FIFO.
//
// Parameters:
//   DEPTH    : FIFO entries, power of two, >= 4
//   AF_LEVEL : fill level at or above which walmost_full asserts (1..DEPTH)
//
// Ports:
//   wclk, wrst_n   : write clock, asynchronous active-low reset
//   winc           : write request, one word per cycle
//   wq2_rptr       : read Gray pointer in the wclk domain (raw rclk-domain
//                    pointer when ASYNC_FIFO_WSYNC_EN is defined)
//   wovf_clr       : clears the sticky overflow flag
//   wen            : memory write enable (winc & ~wfull), combinational
//   waddr          : binary memory write address
//   wptr           : registered Gray write pointer for the read domain
//   wfull          : FIFO full
//   walmost_full   : fill level >= AF_LEVEL
//   wcount         : write-side fill level, 0..DEPTH
//   wovf           : one-cycle pulse after a write attempt while full
//   wovf_sticky    : latched overflow, held until wovf_clr
//
// Build option:
//   ASYNC_FIFO_WSYNC_EN : insert an internal 2-flop synchroniser on wq2_rptr.
// ----------------------------------------------------------------------------
module async_fifo_wctrl
    import async_fifo_pkg::*;
#(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    localparam int unsigned AW      = $clog2(DEPTH)
) (
    input  logic          wclk,
    input  logic          wrst_n,
    input  logic          winc,
    input  logic [AW:0]   wq2_rptr,
    input  logic          wovf_clr,
    output logic          wen,
    output logic [AW-1:0] waddr,
    output logic [AW:0]   wptr,
    output logic          wfull,
    output logic          walmost_full,
    output logic [AW:0]   wcount,
    output logic          wovf,
    output logic          wovf_sticky
);

    // Keeps wide intermediates to the pointer width.
    localparam ptr_t PtrMask = ptr_t'((64'd1 << (AW + 1)) - 64'd1);

    logic [AW:0] wbin_q, wbin_d;
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] wcount_q, wcount_d;
    logic        wfull_q, wfull_d;
    logic        walmost_full_q, walmost_full_d;
    logic        wovf_q, wovf_d;
    logic        wovf_sticky_q, wovf_sticky_d;

    logic [AW:0] rptr_s;
    logic [AW:0] full_cmp;
    ptr_t        wgray_w;
    ptr_t        rbin_w;
    ptr_t        wdiff_w;

`ifdef ASYNC_FIFO_WSYNC_EN
    async_fifo_sync2 #(
        .WIDTH (AW + 1)
    ) u_rptr_sync (
        .clk_i  (wclk),
        .rst_ni (wrst_n),
        .d_i    (wq2_rptr),
        .q_o    (rptr_s)
    );
`else
    assign rptr_s = wq2_rptr;
`endif

    assign wen = winc & ~wfull_q;

    // Full when the next write pointer equals the read pointer with the two
    // MSBs inverted: same index, one lap ahead.
    assign full_cmp = {~rptr_s[AW:AW-1], rptr_s[AW-2:0]};

    always_comb begin
        wbin_d         = wbin_q + {{AW{1'b0}}, wen};
        wgray_w        = bin2gray(ptr_t'(wbin_d));
        wptr_d         = wgray_w[AW:0];
        rbin_w         = gray2bin(ptr_t'(rptr_s));
        // Modulo 2^(AW+1) difference gives the fill level across wrap.
        wdiff_w        = (ptr_t'(wbin_d) - rbin_w) & PtrMask;
        wcount_d       = wdiff_w[AW:0];
        walmost_full_d = (wdiff_w >= ptr_t'(AF_LEVEL));
        wfull_d        = (wgray_w == ptr_t'(full_cmp));
        wovf_d         = winc & wfull_q;
        // A new overflow wins over a coincident clear.
        wovf_sticky_d  = wovf_d | (wovf_sticky_q & ~wovf_clr);
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin_q         <= '0;
            wptr_q         <= '0;
            wcount_q       <= '0;
            wfull_q        <= 1'b0;
            walmost_full_q <= 1'b0;
            wovf_q         <= 1'b0;
            wovf_sticky_q  <= 1'b0;
        end else begin
            wbin_q         <= wbin_d;
            wptr_q         <= wptr_d;
            wcount_q       <= wcount_d;
            wfull_q        <= wfull_d;
            walmost_full_q <= walmost_full_d;
            wovf_q         <= wovf_d;
            wovf_sticky_q  <= wovf_sticky_d;
        end
    end

    assign waddr        = wbin_q[AW-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = walmost_full_q;
    assign wcount       = wcount_q;
    assign wovf         = wovf_q;
    assign wovf_sticky  = wovf_sticky_q;

endmodule

// File: tb/tb_async_fifo_wctrl.sv
// ----------------------------------------------------------------------------
// tb_async_fifo_wctrl
// Directed bench for async_fifo_wctrl at DEPTH=16, AF_LEVEL=14.
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, away from the edge.
// ----------------------------------------------------------------------------
module tb_async_fifo_wctrl;

`ifdef ASYNC_FIFO_WSYNC_EN
    localparam int SyncLat = 2;
`else
    localparam int SyncLat = 0;
`endif

    logic       wclk;
    logic       wrst_n;
    logic       winc;
    logic [4:0] wq2_rptr;
    logic       wovf_clr;
    logic       wen;
    logic [3:0] waddr;
    logic [4:0] wptr;
    logic       wfull;
    logic       walmost_full;
    logic [4:0] wcount;
    logic       wovf;
    logic       wovf_sticky;

    int checks = 0;
    int errors = 0;

    async_fifo_wctrl #(
        .DEPTH    (16),
        .AF_LEVEL (14)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wovf_clr     (wovf_clr),
        .wen          (wen),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wcount       (wcount),
        .wovf         (wovf),
        .wovf_sticky  (wovf_sticky)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic       clr;
        logic [4:0] rptr;
        logic       wen;
        logic [3:0] waddr;
        logic [4:0] wptr;
        logic [4:0] wcount;
        logic       full;
        logic       af;
        logic       ovf;
        logic       sticky;
    } vec_t;

    vec_t vecs[$];

    // Reflected binary code for 0..16, written out by hand.
    logic [4:0] gray_tbl [17] = '{5'd0, 5'd1, 5'd3, 5'd2, 5'd6, 5'd7, 5'd5, 5'd4,
                                  5'd12, 5'd13, 5'd15, 5'd14, 5'd10, 5'd11, 5'd9,
                                  5'd8, 5'd24};

    function automatic logic [4:0] gray5(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    task automatic add_vec(input logic wi, input logic cl, input logic [4:0] rp,
                           input logic e_wen, input logic [3:0] e_addr,
                           input logic [4:0] e_ptr, input logic [4:0] e_cnt,
                           input logic e_full, input logic e_af, input logic e_ovf,
                           input logic e_sticky);
        vec_t v;
        v.winc   = wi;
        v.clr    = cl;
        v.rptr   = rp;
        v.wen    = e_wen;
        v.waddr  = e_addr;
        v.wptr   = e_ptr;
        v.wcount = e_cnt;
        v.full   = e_full;
        v.af     = e_af;
        v.ovf    = e_ovf;
        v.sticky = e_sticky;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        wrst_n = 1'b0;
        #2;
        @(negedge wclk);
        wrst_n = 1'b1;
        tick();
    endtask

    logic [4:0] prev_ptr;
    logic [4:0] cnt;

    initial begin
        wrst_n   = 1'b0;
        winc     = 1'b0;
        wq2_rptr = '0;
        wovf_clr = 1'b0;
        #2;
        chk("por_wptr", 32'(wptr), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;

        // Reset mid-traffic: five writes, then an asynchronous reset.
        winc = 1'b1;
        repeat (5) tick();
        chk("pre_rst_waddr", 32'(waddr), 32'd5);
        chk("pre_rst_wcount", 32'(wcount), 32'd5);
        winc   = 1'b0;
        wrst_n = 1'b0;
        #1;
        chk("rst_waddr", 32'(waddr), 32'd0);
        chk("rst_wptr", 32'(wptr), 32'd0);
        chk("rst_wcount", 32'(wcount), 32'd0);
        chk("rst_flags", 32'({wen, wfull, walmost_full, wovf, wovf_sticky}), 32'd0);
        @(negedge wclk);
        wrst_n = 1'b1;
        tick();

        // Fill: 16 back-to-back writes with the read pointer at 0.
        for (int k = 1; k <= 16; k++) begin
            add_vec(1'b1, 1'b0, 5'd0, 1'b1, 4'(k), gray_tbl[k], 5'(k),
                    (k == 16), (k >= 14), 1'b0, 1'b0);
        end
        // Overflow while full; the third one has a coincident clear.
        add_vec(1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1);
        add_vec(1'b1, 1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1);
        add_vec(1'b1, 1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b0, 1'b1);
        add_vec(1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0);
        add_vec(1'b0, 1'b0, 5'd0, 1'b0, 4'd0, 5'd24, 5'd16, 1'b1, 1'b1, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            winc     = vecs[i].winc;
            wovf_clr = vecs[i].clr;
            wq2_rptr = vecs[i].rptr;
            #1;
            chk($sformatf("v%0d_wen", i), 32'(wen), 32'(vecs[i].wen));
            tick();
            chk($sformatf("v%0d_waddr", i), 32'(waddr), 32'(vecs[i].waddr));
            chk($sformatf("v%0d_wptr", i), 32'(wptr), 32'(vecs[i].wptr));
            chk($sformatf("v%0d_wcount", i), 32'(wcount), 32'(vecs[i].wcount));
            chk($sformatf("v%0d_wfull", i), 32'(wfull), 32'(vecs[i].full));
            chk($sformatf("v%0d_walmost_full", i), 32'(walmost_full), 32'(vecs[i].af));
            chk($sformatf("v%0d_wovf", i), 32'(wovf), 32'(vecs[i].ovf));
            chk($sformatf("v%0d_wovf_sticky", i), 32'(wovf_sticky), 32'(vecs[i].sticky));
        end

        // Drain: read pointer advances to 4 words; full stays up through any
        // synchroniser stages, then drops with the status register.
        wovf_clr = 1'b0;
        winc     = 1'b0;
        wq2_rptr = 5'd6;
        for (int j = 0; j < SyncLat; j++) begin
            tick();
            chk($sformatf("drain_hold%0d_wfull", j), 32'(wfull), 32'd1);
        end
        tick();
        chk("drain_wfull", 32'(wfull), 32'd0);
        chk("drain_wcount", 32'(wcount), 32'd12);
        chk("drain_walmost_full", 32'(walmost_full), 32'd0);
        chk("drain_waddr", 32'(waddr), 32'd0);
        #1;
        winc = 1'b1;
        #1;
        chk("drain_wen", 32'(wen), 32'd1);
        winc = 1'b0;

        // Wrap: lockstep write/read with the read pointer trailing by 2.
        do_reset();
        wq2_rptr = '0;
        winc     = 1'b1;
        tick();
        tick();
        prev_ptr = wptr;
        chk("wrap_start_wptr", 32'(wptr), 32'd3);
        for (int i = 0; i < 40; i++) begin
            cnt      = 5'(i + 2);
            wq2_rptr = gray5(5'(i));
            tick();
            chk($sformatf("wrap%0d_wptr", i), 32'(wptr), 32'(gray5(cnt + 5'd1)));
            chk($sformatf("wrap%0d_onebit", i), 32'($countones(wptr ^ prev_ptr)), 32'd1);
            chk($sformatf("wrap%0d_wfull", i), 32'(wfull), 32'd0);
            if (i >= 2) begin
                chk($sformatf("wrap%0d_wcount", i), 32'(wcount), 32'(3 + SyncLat));
            end
            prev_ptr = wptr;
        end
        winc = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/async_fifo_wctrl.md
Name: async_fifo_wctrl

Overview:
Write-domain pointer and status controller for the async FIFO, parametrised in depth and almost-full threshold. Generates the binary write address and the Gray write pointer for the read-domain synchroniser. Produces full, almost-full, fill-level and overflow status from the synchronised read pointer. Sits between the write-side client and the dual-port FIFO memory; pairs with the read-side controller.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4; AW = $clog2(DEPTH)
AF_LEVEL, DEPTH-2, fill level (in words) at or above which walmost_full asserts; legal range 1..DEPTH

Ports:
wclk  in  1  write clock
wrst_n  in  1  asynchronous active-low reset
winc  in  1  write request (one word per cycle)
wq2_rptr  in  AW+1  read Gray pointer, already synchronised into wclk (raw rptr when ASYNC_FIFO_WSYNC_EN is defined)
wovf_clr  in  1  clears sticky overflow flag
wen  out  1  memory write enable = winc & ~wfull
waddr  out  AW  binary memory write address
wptr  out  AW+1  registered Gray write pointer
wfull  out  1  FIFO full
walmost_full  out  1  fill level >= AF_LEVEL
wcount  out  AW+1  write-side fill level, 0..DEPTH
wovf  out  1  one-cycle pulse: write attempted while full
wovf_sticky  out  1  latched overflow

Behaviour:
- Reset (async, wrst_n low): wbin, wptr, wcount = 0; wfull, walmost_full, wovf, wovf_sticky = 0. Leaving reset is synchronous to wclk.
- wbinnext = wbin + (winc & ~wfull), modulo 2^(AW+1). wgraynext = (wbinnext >> 1) ^ wbinnext. Both wbin and wptr register on each wclk edge.
- waddr = wbin[AW-1:0]. wen is combinational and is the only write qualifier to memory.
- rbin_s = Gray-to-binary(wq2_rptr), combinational. wcount_next = (wbinnext - rbin_s) mod 2^(AW+1). wcount registers wcount_next.
- wfull registers (wgraynext == {~wq2_rptr[AW:AW-1], wq2_rptr[AW-2:0]}). Asserts in the same cycle the DEPTH-th word is written.
- walmost_full registers (wcount_next >= AF_LEVEL).
- wfull deasserts only after the read pointer advances through synchronisation. The status is pessimistic: it is never falsely low.
- Overflow: winc & wfull causes the write to be dropped, with no pointer or address change. wovf pulses high the next cycle. wovf_sticky sets and holds until wovf_clr. If wovf_clr and a new overflow occur in the same cycle, set wins.
- Wrap-around: the pointer rolls 2^(AW+1)-1 -> 0 seamlessly. Gray changes exactly one bit per increment, including at wrap.
- winc while not full advances the pointer by exactly 1, and wcount increases by 1 the next cycle, unless rbin_s also moved.

Optional Feature:
ASYNC_FIFO_WSYNC_EN
- Defined: wq2_rptr carries the raw rclk-domain Gray pointer. It passes through an internal 2-flop synchroniser, reset to 0 by wrst_n, before use. This adds 2 wclk cycles of read-pointer visibility latency.
- Undefined: wq2_rptr is used directly, with no added flops.

Decomposition:
- Package async_fifo_pkg: bin2gray and gray2bin functions, parameterised by width. The read controller uses the same package.
- Sub-module async_fifo_sync2: width-parameterised 2-flop synchroniser with async active-low reset. It is instantiated only under ASYNC_FIFO_WSYNC_EN and is shared with the read side.

Test Plan (DEPTH=16, AF_LEVEL=14, wq2_rptr held at 0, macro off unless stated):
- Reset mid-traffic: after 5 writes, pulse wrst_n low -> all outputs 0 immediately (asynchronously); waddr=0.
- 16 back-to-back writes -> waddr 0..15; wptr follows the Gray sequence; walmost_full=1 after write 14; wfull=1 after write 16; wcount=16.
- winc held while full for 3 cycles -> waddr/wptr frozen; wen=0; wovf pulses each cycle; wovf_sticky=1 until wovf_clr; clr coincident with overflow leaves sticky=1.
- Drain: set wq2_rptr to Gray(4) -> next cycle wfull=0, wcount=12, walmost_full=0.
- Wrap: write/read 40 words in lockstep with the read pointer trailing by 2 -> wptr crosses 31->0 with a single-bit Gray change; no false wfull.
- With ASYNC_FIFO_WSYNC_EN: wq2_rptr changes while full -> wfull drops exactly 3 wclk cycles later (2 sync flops + status register).
